fetch_unit: RTL and testbench

- Instruction-fetch stage of the LEGv8 CPU, directly upstream of the control/decode stage.
- Holds the PC and issues word fetches to instruction memory over a request/response handshake.
- Buffers returned instructions in a small FIFO and presents them, with opcode field [31:21] split out, to decode under valid/ready.
- Handles branch redirects from CBZ resolution: flushes the FIFO and discards any in-flight fetch.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, fetches one word at a time from
// instruction memory and queues the returned words for decode, with branch redirect.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [10:0] id_opcode,
    output logic [63:0] id_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [63:0]     req_pc_q, req_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]     instr_mem [DEPTH];
    logic [63:0]     pc_mem    [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;

    // Requests only go out while a slot is free, so a returning word always fits.
    assign imem_req_valid = (state_q == S_REQ) && (count_q < CW'(DEPTH)) && !rst;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign id_valid  = (count_q != '0);
    assign id_instr  = id_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign id_pc     = id_valid ? pc_mem[rd_ptr_q] : 64'h0;
    assign id_opcode = id_instr[31:21];

    // A redirect wins over both ends of the FIFO in the same cycle.
    assign push = (state_q == S_WAIT) && imem_rsp_valid && !redirect;
    assign pop  = id_valid && id_ready && !redirect;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d  = redirect ? S_DRAIN : S_WAIT;
                    pc_d     = pc_q + 64'd4;
                    req_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 64'h0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]    <= req_pc_q;
        end
        if (!rst) begin
            assert (!(push && !pop && (count_q == CW'(DEPTH))));
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory, request and decode-side
// scoreboards fed by the stimulus, and checks around redirect and reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [10:0] id_opcode;
    logic [63:0] id_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_pc(id_pc)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } id_exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_req_q[$];
    id_exp_t     exp_id_q[$];
    int          n_pops = 0;
    int          n_accepts = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          prev_pop_cyc = 0;

    int          mem_lat  = 1;
    bit          mem_keep = 1'b0;
    bit          mem_pend = 1'b0;
    int          mem_dly  = 0;
    logic [63:0] mem_addr = 64'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %h, expected nothing queued", name, act);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(input logic [63:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_id(input logic [63:0] pc);
        id_exp_t e;
        e.pc    = pc;
        e.instr = 32'h8B000000 | pc[31:0];
        exp_id_q.push_back(e);
    endtask

    task automatic do_reset();
        mem_keep = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_accept(input logic [63:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (imem_req_valid && imem_req_ready && imem_req_addr == a) found = 1'b1;
            else tick();
        end
        chk("wait_accept", 64'(found), 64'd1);
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 300 && n_pops < target; i++) tick();
        chk("wait_pops", 64'(n_pops >= target), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: one outstanding word, returned mem_lat cycles after acceptance.
    always @(negedge clk) begin
        #2;
        imem_rsp_valid = 1'b0;
        if (rst && !mem_keep) begin
            mem_pend = 1'b0;
        end else begin
            if (mem_pend) begin
                if (mem_dly <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_addr[31:0] | 32'h8B000000;
                    mem_pend       = 1'b0;
                end else begin
                    mem_dly--;
                end
            end
            if (!rst && imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_dly  = mem_lat;
                mem_addr = imem_req_addr;
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_req_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            n_accepts++;
            if (exp_req_q.size() == 0) extra("req_addr", imem_req_addr);
            else chk("req_addr", imem_req_addr, exp_req_q.pop_front());
            $display("req   addr=%h", imem_req_addr);
        end
    end

    always @(negedge clk) begin
        id_exp_t e;
        #3;
        if (rst) begin
            exp_id_q.delete();
        end else if (id_valid && id_ready && !redirect) begin
            n_pops++;
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
            if (exp_id_q.size() == 0) begin
                extra("id_pc", id_pc);
            end else begin
                e = exp_id_q.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_instr", 64'(id_instr), 64'(e.instr));
                chk("id_opcode", 64'(id_opcode), 64'h458);
            end
            $display("id    pc=%h instr=%h opcode=%h", id_pc, id_instr, id_opcode);
        end
    end

    initial begin
        int base;
        int base_acc;

        tick();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'd0);
        chk("rst_id_opcode", 64'(id_opcode), 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);

        // Streaming with a 1-cycle memory.
        id_ready = 1'b1; mem_lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin push_req(64'(i * 4)); push_id(64'(i * 4)); end
        base = n_pops;
        wait_pops(base + 3);
        chk("pop_interval", 64'(last_pop_cyc - prev_pop_cyc), 64'd2);

        // Decode stalled: FIFO fills after two fetches, then drains in order.
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) push_req(64'(i * 4));
        for (int i = 0; i < 4; i++) push_id(64'(i * 4));
        base_acc = n_accepts;
        base = n_pops;
        repeat (20) tick();
        chk("stall_req_count", 64'(n_accepts - base_acc), 64'd2);
        chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
        chk("stall_id_valid", 64'(id_valid), 64'd1);
        chk("stall_head_pc", id_pc, 64'h0);
        id_ready = 1'b1;
        wait_pops(base + 3);

        // Redirect while waiting; the stale word arrives during drain.
        mem_lat = 3;
        do_reset();
        push_req(64'h0); push_req(64'h4); push_req(64'h8);
        push_req(64'h100); push_req(64'h104); push_req(64'h108);
        push_id(64'h0); push_id(64'h4); push_id(64'h100); push_id(64'h104);
        base = n_pops;
        wait_accept(64'h8);
        tick();
        redirect = 1'b1; redirect_pc = 64'h100;
        tick();
        redirect = 1'b0;
        chk("drain1_id_valid", 64'(id_valid), 64'd0);
        chk("drain1_id_opcode", 64'(id_opcode), 64'd0);
        chk("drain1_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        chk("drain2_id_valid", 64'(id_valid), 64'd0);
        chk("drain2_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        chk("after_drain_req_valid", 64'(imem_req_valid), 64'd1);
        chk("after_drain_req_addr", imem_req_addr, 64'h100);
        wait_pops(base + 4);

        // Redirect coinciding with a response.
        mem_lat = 1;
        do_reset();
        push_req(64'h0); push_req(64'h4);
        push_req(64'h200); push_req(64'h204); push_req(64'h208);
        push_id(64'h0); push_id(64'h200); push_id(64'h204);
        base = n_pops;
        wait_accept(64'h4);
        tick();
        redirect = 1'b1; redirect_pc = 64'h200;
        tick();
        redirect = 1'b0;
        chk("rsp_redir_id_valid", 64'(id_valid), 64'd0);
        chk("rsp_redir_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rsp_redir_req_addr", imem_req_addr, 64'h200);
        wait_pops(base + 3);

        // Redirect coinciding with acceptance; the queued word at 0x8 is flushed.
        do_reset();
        push_req(64'h0); push_req(64'h4); push_req(64'h8); push_req(64'hC);
        push_req(64'h40); push_req(64'h44); push_req(64'h48);
        push_id(64'h0); push_id(64'h4); push_id(64'h40); push_id(64'h44);
        base = n_pops;
        wait_accept(64'hC);
        redirect = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect = 1'b0;
        chk("acc_redir_req_valid", 64'(imem_req_valid), 64'd0);
        chk("acc_redir_id_valid", 64'(id_valid), 64'd0);
        tick();
        chk("acc_redir_next_valid", 64'(imem_req_valid), 64'd1);
        chk("acc_redir_next_addr", imem_req_addr, 64'h40);
        wait_pops(base + 4);

        // Asynchronous reset in the middle of a fetch.
        id_ready = 1'b0; mem_lat = 3;
        do_reset();
        push_req(64'h0); push_req(64'h4);
        wait_accept(64'h4);
        tick();
        chk("pre_rst_id_valid", 64'(id_valid), 64'd1);
        chk("pre_rst_id_pc", id_pc, 64'h0);
        mem_keep = 1'b1;
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_req_valid", 64'(imem_req_valid), 64'd0);
        chk("async_id_valid", 64'(id_valid), 64'd0);
        chk("async_id_instr", 64'(id_instr), 64'd0);
        chk("async_id_opcode", 64'(id_opcode), 64'd0);
        chk("async_id_pc", id_pc, 64'd0);
        tick();
        rst = 1'b0;
        push_req(64'h0); push_req(64'h4); push_req(64'h8); push_req(64'hC);
        push_id(64'h0); push_id(64'h4); push_id(64'h8);
        base = n_pops;
        tick();
        chk("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("post_rst_req_addr", imem_req_addr, 64'h0);
        tick();
        chk("stale_ignored_id_valid", 64'(id_valid), 64'd0);
        mem_keep = 1'b0; mem_lat = 1;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        wait_pops(base + 3);

        imem_req_ready = 1'b0;
        id_ready = 1'b0;
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
